// File: rtl/ysyx_25040109_axi_pkg.sv
// Shared AXI4-Lite response codes, CLINT address map and FSM encodings for the
// core-local timer block.
package ysyx_25040109_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] CLINT_BASE = 32'h1001_0000;
  localparam logic [31:0] CLINT_LO   = 32'h0000_0000;
  localparam logic [31:0] CLINT_HI   = 32'h0000_0004;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_COMMIT  = 2'd1,
    W_RESP    = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LO   = 2'd1,
    SEL_HI   = 2'd2
  } word_sel_e;

  function automatic word_sel_e decode_word(input logic [31:0] addr,
                                            input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    if (off == CLINT_LO) return SEL_LO;
    if (off == CLINT_HI) return SEL_HI;
    return SEL_NONE;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_25040109_mtime_counter.sv
// Prescaled free-running 64-bit mtime with a byte-masked 32-bit word write
// port; a write always takes priority over the tick in the same cycle.
module ysyx_25040109_mtime_counter
  import ysyx_25040109_axi_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [63:0] mtime
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [63:0]      mtime_q, mtime_d;

  // A write restarts the prescaler so the next tick is a full period away.
  always_comb begin
    div_cnt_d = div_cnt_q;
    mtime_d   = mtime_q;
    if (wr_en) begin
      div_cnt_d = '0;
      if (wr_hi) mtime_d[63:32] = merge_bytes(mtime_q[63:32], wr_data, wr_strb);
      else       mtime_d[31:0]  = merge_bytes(mtime_q[31:0], wr_data, wr_strb);
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      mtime_d   = mtime_q + 64'd1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      mtime_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      mtime_q   <= mtime_d;
    end
  end

  assign mtime = mtime_q;

endmodule

// File: rtl/ysyx_25040109_clint.sv
// AXI4-Lite responder exposing mtime as two 32-bit words, with independent
// read and write FSMs and a hi-word shadow for coherent LO->HI reads.
module ysyx_25040109_clint
  import ysyx_25040109_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = CLINT_BASE,
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);

  localparam int unsigned WAIT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  r_state_e    r_state_q, r_state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        shadow_vld_q, shadow_vld_d;
  word_sel_e   ar_sel;

  w_state_e    w_state_q, w_state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  word_sel_e   w_sel_q, w_sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  word_sel_e   aw_sel;
  logic        cnt_wr_en;
  logic [63:0] mtime;

  ysyx_25040109_mtime_counter #(.TICK_DIV(TICK_DIV)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cnt_wr_en),
    .wr_hi   (w_sel_q == SEL_HI),
    .wr_data (wdata_q),
    .wr_strb (wstrb_q),
    .mtime   (mtime)
  );

  // Read data is captured at the AR handshake, i.e. before this cycle's tick or commit.
  always_comb begin
    r_state_d    = r_state_q;
    wait_d       = wait_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    hi_shadow_d  = hi_shadow_q;
    shadow_vld_d = shadow_vld_q;
    ar_sel       = decode_word(araddr, BASE_ADDR);
    case (r_state_q)
      R_IDLE: if (arvalid) begin
        r_state_d = (RD_LATENCY == 1) ? R_RESP : R_WAIT;
        wait_d    = WAIT_INIT;
        unique case (ar_sel)
          SEL_LO: begin
            rdata_d      = mtime[31:0];
            rresp_d      = RESP_OKAY;
            hi_shadow_d  = mtime[63:32];
            shadow_vld_d = 1'b1;
          end
          SEL_HI: begin
            rdata_d      = shadow_vld_q ? hi_shadow_q : mtime[63:32];
            rresp_d      = RESP_OKAY;
            shadow_vld_d = 1'b0;
          end
          default: begin
            rdata_d = 32'd0;
            rresp_d = RESP_SLVERR;
          end
        endcase
      end
      R_WAIT: begin
        if (wait_q == '0) r_state_d = R_RESP;
        else              wait_d    = wait_q - WAIT_W'(1);
      end
      R_RESP: if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    if (w_state_q == W_COMMIT && w_sel_q != SEL_NONE) shadow_vld_d = 1'b0;
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    w_sel_d   = w_sel_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    cnt_wr_en = 1'b0;
    aw_sel    = decode_word(awaddr, BASE_ADDR);
    case (w_state_q)
      W_COLLECT: begin
        if (awvalid && !aw_got_q) begin
          aw_got_d = 1'b1;
          w_sel_d  = aw_sel;
          bresp_d  = (aw_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        end
        if (wvalid && !w_got_q) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if (aw_got_d && w_got_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        cnt_wr_en = (w_sel_q != SEL_NONE);
        w_state_d = W_RESP;
      end
      W_RESP: if (bready) begin
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        w_state_d = W_COLLECT;
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q    <= R_IDLE;
      wait_q       <= '0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      hi_shadow_q  <= '0;
      shadow_vld_q <= 1'b0;
      w_state_q    <= W_COLLECT;
      aw_got_q     <= 1'b0;
      w_got_q      <= 1'b0;
      w_sel_q      <= SEL_NONE;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bresp_q      <= RESP_OKAY;
    end else begin
      r_state_q    <= r_state_d;
      wait_q       <= wait_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      hi_shadow_q  <= hi_shadow_d;
      shadow_vld_q <= shadow_vld_d;
      w_state_q    <= w_state_d;
      aw_got_q     <= aw_got_d;
      w_got_q      <= w_got_d;
      w_sel_q      <= w_sel_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bresp_q      <= bresp_d;
    end
  end

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = (w_state_q == W_COLLECT) && !aw_got_q;
  assign wready  = (w_state_q == W_COLLECT) && !w_got_q;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_25040109_clint.sv
// Directed bench for the CLINT: a table of register accesses plus hand-written
// sequences for channel ordering, read latency, coherent snapshots and reset.
module tb_ysyx_25040109_clint;
  import ysyx_25040109_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RD_LATENCY=1) signals
  logic        arvalid = 0, rready = 1, awvalid = 0, wvalid = 0, bready = 1;
  logic [31:0] araddr = 0, awaddr = 0, wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  // Second instance (RD_LATENCY=3), read channel only; write side held idle
  logic        arvalid_3 = 0, rready_3 = 1, awvalid_3 = 0, wvalid_3 = 0, bready_3 = 1;
  logic [31:0] araddr_3 = 0, awaddr_3 = 0, wdata_3 = 0;
  logic [3:0]  wstrb_3 = 0;
  logic        arready_3, rvalid_3, awready_3, wready_3, bvalid_3;
  logic [31:0] rdata_3;
  logic [1:0]  rresp_3, bresp_3;

  ysyx_25040109_clint dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  ysyx_25040109_clint #(.RD_LATENCY(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid_3), .arready(arready_3), .araddr(araddr_3),
    .rvalid(rvalid_3), .rready(rready_3), .rdata(rdata_3), .rresp(rresp_3),
    .awvalid(awvalid_3), .awready(awready_3), .awaddr(awaddr_3),
    .wvalid(wvalid_3), .wready(wready_3), .wdata(wdata_3), .wstrb(wstrb_3),
    .bvalid(bvalid_3), .bready(bready_3), .bresp(bresp_3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mtime ticks every cycle except on the edge a mapped write commits
  logic [63:0] m_time, m3_time;
  logic        m_wr_en = 0, m_wr_hi = 0;
  logic [31:0] m_wr_data = 0;
  logic [3:0]  m_wr_strb = 0;
  logic [31:0] m_shadow = 0;
  logic        m_shadow_vld = 0;

  function automatic logic [31:0] mergeWord(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) m_time <= 64'd0;
    else if (m_wr_en && m_wr_hi) m_time[63:32] <= mergeWord(m_time[63:32], m_wr_data, m_wr_strb);
    else if (m_wr_en) m_time[31:0] <= mergeWord(m_time[31:0], m_wr_data, m_wr_strb);
    else m_time <= m_time + 64'd1;
  end

  always @(posedge clk) begin
    if (!rst_n) m3_time <= 64'd0;
    else m3_time <= m3_time + 64'd1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: handshake timed out", name);
  endtask

  // Value the DUT must capture for a read whose AR handshake is on the coming edge
  task automatic modelRead(input logic [31:0] addr, output logic [31:0] exp);
    logic [31:0] off;
    off = addr - BASE;
    if (off == 32'd0) begin
      exp = m_time[31:0];
      m_shadow = m_time[63:32];
      m_shadow_vld = 1'b1;
    end else if (off == 32'd4) begin
      exp = m_shadow_vld ? m_shadow : m_time[63:32];
      m_shadow_vld = 1'b0;
    end else begin
      exp = 32'd0;
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the R handshake
  task automatic doRead(input string name, input logic [31:0] addr, input logic [1:0] exp_resp,
                        output logic [31:0] got, output int lat);
    bit hs, seen;
    logic [31:0] exp;
    hs = 0; seen = 0; lat = 0; got = 0; exp = 0;
    arvalid = 1; araddr = addr;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      if (arready) begin hs = 1; modelRead(addr, exp); end
      @(posedge clk); #1;
    end
    arvalid = 0;
    if (!hs) begin timeoutFail({name, " ar"}); return; end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (rvalid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin timeoutFail({name, " r"}); return; end
    got = rdata;
    checkOutput({name, " rdata"}, rdata, exp);
    checkOutput({name, " rresp"}, rresp, exp_resp);
    @(posedge clk); #1;
  endtask

  // Caller is at posedge+1; AW and W are raised after their own delays
  task automatic doWrite(input string name, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_dly, input int w_dly,
                         input logic [1:0] exp_resp, input bit hold_b);
    bit got;
    logic [31:0] off;
    got = 0;
    off = addr - BASE;
    fork
      begin
        bit hs;
        hs = 0;
        repeat (aw_dly) begin @(posedge clk); #1; end
        awvalid = 1; awaddr = addr;
        for (int i = 0; i < 20 && !hs; i++) begin
          @(negedge clk); hs = awready; @(posedge clk); #1;
        end
        awvalid = 0;
        if (!hs) timeoutFail({name, " aw"});
      end
      begin
        bit hs;
        hs = 0;
        repeat (w_dly) begin @(posedge clk); #1; end
        wvalid = 1; wdata = data; wstrb = strb;
        for (int i = 0; i < 20 && !hs; i++) begin
          @(negedge clk); hs = wready; @(posedge clk); #1;
        end
        wvalid = 0;
        if (!hs) timeoutFail({name, " w"});
      end
    join
    if (off == 32'd0 || off == 32'd4) begin
      m_wr_en = 1; m_wr_hi = (off == 32'd4); m_wr_data = data; m_wr_strb = strb;
      m_shadow_vld = 0;
    end
    @(posedge clk); #1;
    m_wr_en = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bvalid) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin timeoutFail({name, " b"}); return; end
    checkOutput({name, " bresp"}, bresp, exp_resp);
    if (!hold_b) begin @(posedge clk); #1; end
  endtask

  task automatic noExtraB(input string name);
    int extra;
    extra = 0;
    repeat (3) begin @(negedge clk); if (bvalid) extra++; end
    @(posedge clk); #1;
    checkOutput({name, " extra bvalid"}, extra, 0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs[15];

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [31:0] rd;
    int lat;
    if (v.is_wr) doWrite($sformatf("v%0d wr", idx), v.addr, v.data, v.strb, 0, 0, v.resp, 0);
    else doRead($sformatf("v%0d rd", idx), v.addr, v.resp, rd, lat);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd, rd0, exp3;
    int lat, bad;
    bit seen;

    vecs[0]  = '{1'b1, BASE,               32'h1234_5678, 4'hF, RESP_OKAY};
    vecs[1]  = '{1'b0, BASE,               32'h0,         4'h0, RESP_OKAY};
    vecs[2]  = '{1'b0, BASE + 32'h4,       32'h0,         4'h0, RESP_OKAY};
    vecs[3]  = '{1'b1, BASE + 32'h4,       32'hAABB_CCDD, 4'h5, RESP_OKAY};
    vecs[4]  = '{1'b0, BASE,               32'h0,         4'h0, RESP_OKAY};
    vecs[5]  = '{1'b0, BASE + 32'h4,       32'h0,         4'h0, RESP_OKAY};
    vecs[6]  = '{1'b0, BASE + 32'h8,       32'h0,         4'h0, RESP_SLVERR};
    vecs[7]  = '{1'b1, BASE + 32'hC,       32'hDEAD_BEEF, 4'hF, RESP_SLVERR};
    vecs[8]  = '{1'b0, BASE,               32'h0,         4'h0, RESP_OKAY};
    vecs[9]  = '{1'b0, BASE + 32'h4,       32'h0,         4'h0, RESP_OKAY};
    vecs[10] = '{1'b1, BASE,               32'hFFFF_FFFF, 4'h0, RESP_OKAY};
    vecs[11] = '{1'b0, BASE,               32'h0,         4'h0, RESP_OKAY};
    vecs[12] = '{1'b0, 32'h0000_0000,      32'h0,         4'h0, RESP_SLVERR};
    vecs[13] = '{1'b1, BASE + 32'h2,       32'h0BAD_0BAD, 4'hF, RESP_SLVERR};
    vecs[14] = '{1'b0, BASE + 32'h4,       32'h0,         4'h0, RESP_OKAY};

    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    m_shadow_vld = 0;

    @(negedge clk);
    checkOutput("reset handshake flags", {arready, awready, wready, rvalid, bvalid}, 5'b11100);
    checkOutput("reset data/resp", {rdata, rresp, bresp}, 36'd0);
    checkOutput("reset lat3 flags", {arready_3, rvalid_3}, 2'b10);

    // Ten ticks after reset release, LO must read exactly 10
    repeat (10) @(posedge clk);
    #1;
    doRead("t1 lo", BASE, RESP_OKAY, rd, lat);
    checkOutput("t1 lo==10", rd, 10);
    checkOutput("t1 read latency", lat, 1);

    // Coherent LO->HI across a lo-word carry
    doWrite("t2 wr hi", BASE + 32'h4, 32'h0000_0001, 4'hF, 0, 0, RESP_OKAY, 0);
    doWrite("t2 wr lo", BASE, 32'hFFFF_FFFE, 4'hF, 0, 0, RESP_OKAY, 0);
    doRead("t2 rd lo", BASE, RESP_OKAY, rd, lat);
    checkOutput("t2 lo value", rd, 32'hFFFF_FFFF);
    doRead("t2 rd hi", BASE + 32'h4, RESP_OKAY, rd, lat);
    checkOutput("t2 hi snapshot", rd, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    doRead("t2 rd hi live", BASE + 32'h4, RESP_OKAY, rd, lat);
    checkOutput("t2 hi live", rd, 32'h2);

    // AW/W ordering: W first, AW first, then together
    doWrite("t3 w-first", BASE, 32'h0000_1000, 4'hF, 3, 0, RESP_OKAY, 0);
    noExtraB("t3 w-first");
    doWrite("t3 aw-first", BASE + 32'h4, 32'h0000_0000, 4'hF, 0, 2, RESP_OKAY, 0);
    noExtraB("t3 aw-first");
    doWrite("t3 same", BASE, 32'h0000_2000, 4'hF, 0, 0, RESP_OKAY, 0);
    noExtraB("t3 same");
    doRead("t3 rd lo", BASE, RESP_OKAY, rd, lat);
    doRead("t3 rd hi", BASE + 32'h4, RESP_OKAY, rd, lat);

    // AR handshake on the commit edge sees the pre-write HI word
    fork
      doWrite("ts wr hi", BASE + 32'h4, 32'h0000_ABCD, 4'hF, 0, 0, RESP_OKAY, 0);
      begin
        @(posedge clk); #1;
        doRead("ts rd hi", BASE + 32'h4, RESP_OKAY, rd, lat);
        checkOutput("ts pre-write hi", rd, 32'h0);
      end
    join
    doRead("ts rd lo", BASE, RESP_OKAY, rd, lat);
    doRead("ts rd hi after", BASE + 32'h4, RESP_OKAY, rd, lat);
    checkOutput("ts hi after", rd, 32'h0000_ABCD);

    for (int i = 0; i < 15; i++) applyStimulus(i, vecs[i]);

    // RD_LATENCY=3 instance with a stalled R channel
    rready_3 = 0;
    arvalid_3 = 1; araddr_3 = BASE;
    @(negedge clk);
    checkOutput("t5 arready idle", arready_3, 1);
    exp3 = m3_time[31:0];
    @(posedge clk); #1;
    arvalid_3 = 0;
    lat = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (rvalid_3) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checkOutput("t5 latency", lat, 3);
    checkOutput("t5 rdata", rdata_3, exp3);
    checkOutput("t5 rresp", rresp_3, RESP_OKAY);
    rd0 = rdata_3;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rdata_3 !== rd0 || rvalid_3 !== 1'b1 || arready_3 !== 1'b0) bad++;
    end
    checkOutput("t5 stall stable", bad, 0);
    @(posedge clk); #1 rready_3 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t5 after r handshake", {rvalid_3, arready_3}, 2'b01);
    @(posedge clk); #1;

    // Reset while a write response is still pending
    bready = 0;
    doWrite("t6 wr", BASE, 32'h0000_0055, 4'hF, 0, 0, RESP_OKAY, 1);
    @(posedge clk); #1 rst_n = 0;
    m_shadow_vld = 0;
    @(posedge clk); #1 rst_n = 1;
    bready = 1;
    @(negedge clk);
    checkOutput("t6 flags after reset", {bvalid, awready, wready, arready, rvalid}, 5'b01110);
    @(posedge clk); #1;
    doRead("t6 rd lo", BASE, RESP_OKAY, rd, lat);
    // mtime was 0 after the reset edge and has ticked once before the AR handshake
    checkOutput("t6 mtime restarted", rd, 32'h1);
    noExtraB("t6 no b after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
